// File: rtl/text_cursor_writer_if.sv
// Byte-stream handshake between the UART receive path and the text cursor writer.
interface text_cursor_writer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/text_cursor_writer.sv
// Character-stream front end for the text buffer RAM write port.
// Define TEXT_LINE_CLEAR_EN to blank each newly entered row with FILL_CHAR.
module text_cursor_writer #(
    parameter int         ROWS      = 4,
    parameter int         COLS      = 32,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                    clk,
    input  logic                    reset,
    text_cursor_writer_if.slave     rx,
    output logic                    we,
    output logic [$clog2(ROWS)-1:0] w_row,
    output logic [$clog2(COLS)-1:0] w_col,
    output logic [7:0]              din,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [$clog2(COLS)-1:0] cur_col
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    logic          accept;
    logic          is_print;
    logic          is_cr;
    logic          is_lf;
    logic          is_bs;
    logic          at_last;
    logic          new_line;
    logic [RW-1:0] next_row;

    assign accept   = rx.rx_valid & rx.rx_ready;
    assign is_print = (rx.rx_data >= 8'h20) && (rx.rx_data <= 8'h7E);
    assign is_cr    = (rx.rx_data == 8'h0D);
    assign is_lf    = (rx.rx_data == 8'h0A);
    assign is_bs    = (rx.rx_data == 8'h08);
    assign at_last  = (cur_col == LAST_COL);
    assign next_row = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
    assign new_line = accept & ((is_print & at_last) | is_lf);

`ifdef TEXT_LINE_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic [CW-1:0] clr_col;

    assign rx.rx_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_col <= '0;
        end else if (state == CLEAR) begin
            if (clr_col == LAST_COL) begin
                clr_col <= '0;
                state   <= IDLE;
            end else begin
                clr_col <= clr_col + 1'b1;
            end
        end else if (new_line) begin
            clr_col <= '0;
            state   <= CLEAR;
        end
    end
`else
    assign rx.rx_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            we      <= 1'b0;
            w_row   <= '0;
            w_col   <= '0;
            din     <= '0;
            cur_row <= '0;
            cur_col <= '0;
        end else begin
            we <= 1'b0;
`ifdef TEXT_LINE_CLEAR_EN
            // cur_row already points at the row being blanked
            if (state == CLEAR) begin
                we    <= 1'b1;
                w_row <= cur_row;
                w_col <= clr_col;
                din   <= FILL_CHAR;
            end
`endif
            if (accept) begin
                unique case (1'b1)
                    is_print: begin
                        we    <= 1'b1;
                        w_row <= cur_row;
                        w_col <= cur_col;
                        din   <= rx.rx_data;
                        if (at_last) begin
                            cur_col <= '0;
                            cur_row <= next_row;
                        end else begin
                            cur_col <= cur_col + 1'b1;
                        end
                    end
                    is_cr: cur_col <= '0;
                    is_lf: begin
                        cur_col <= '0;
                        cur_row <= next_row;
                    end
                    is_bs: begin
                        if (cur_col != '0) begin
                            cur_col <= cur_col - 1'b1;
                            we      <= 1'b1;
                            w_row   <= cur_row;
                            w_col   <= cur_col - 1'b1;
                            din     <= FILL_CHAR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_text_cursor_writer.sv
// Scoreboard bench: a cursor/text model predicts every RAM write with its cycle.
module tb_text_cursor_writer;
    localparam int ROWS = 4;
    localparam int COLS = 32;
`ifdef TEXT_LINE_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    typedef struct {
        int due;
        int row;
        int col;
        int data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we;
    logic [1:0] w_row;
    logic [4:0] w_col;
    logic [7:0] din;
    logic [1:0] cur_row;
    logic [4:0] cur_col;

    text_cursor_writer_if rx_if ();

    text_cursor_writer dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx_if),
        .we      (we),
        .w_row   (w_row),
        .w_col   (w_col),
        .din     (din),
        .cur_row (cur_row),
        .cur_col (cur_col)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  started = 1'b0;
    wr_t exp_q[$];
    wr_t e;
    int  m_row = 0;
    int  m_col = 0;
    int  ready_from = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_wr(input int due, input int row, input int col, input int data);
        wr_t w;
        w.due = due;
        w.row = row;
        w.col = col;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic new_line(input int n);
        m_row = (m_row + 1) % ROWS;
        m_col = 0;
        if (CLR_EN) begin
            for (int c = 0; c < COLS; c++) push_wr(n + 1 + c, m_row, c, 8'h20);
            ready_from = n + COLS;
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input int n);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(n, m_row, m_col, int'(b));
            if (m_col == COLS - 1) new_line(n);
            else m_col++;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            new_line(n);
        end else if (b == 8'h08 && m_col > 0) begin
            m_col--;
            push_wr(n, m_row, m_col, 8'h20);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        ready_from = 0;
    endtask

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                if (e.due < cyc || we !== 1'b1 || int'(w_row) != e.row ||
                    int'(w_col) != e.col || int'(din) != e.data) begin
                    errors++;
                    $display("FAIL write cyc %0d: got we=%b (%0d,%0d)=%h, want (%0d,%0d)=%h due %0d",
                             cyc, we, w_row, w_col, din, e.row, e.col, e.data, e.due);
                end
            end else if (we !== 1'b0) begin
                errors++;
                $display("FAIL stray_write cyc %0d: got we=%b (%0d,%0d)=%h, want we=0",
                         cyc, we, w_row, w_col, din);
            end
            checks++;
            if (int'(cur_row) != m_row || int'(cur_col) != m_col) begin
                errors++;
                $display("FAIL cursor cyc %0d: got (%0d,%0d), want (%0d,%0d)",
                         cyc, cur_row, cur_col, m_row, m_col);
            end
            checks++;
            if (rx_if.rx_ready !== (cyc >= ready_from)) begin
                errors++;
                $display("FAIL rx_ready cyc %0d: got %b, want %b",
                         cyc, rx_if.rx_ready, (cyc >= ready_from));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        n = 0;
        while (rx_if.rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rx_if.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got rx_ready=%b after %0d cycles, want 1", rx_if.rx_ready, n);
            rx_if.rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_accept(b, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_if.rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 70) return 8'($urandom_range(32, 126));
        if (r < 78) return 8'h0D;
        if (r < 84) return 8'h0A;
        if (r < 94) return 8'h08;
        do b = 8'($urandom_range(0, 255));
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0D || b == 8'h0A || b == 8'h08);
        return b;
    endfunction

    initial begin
        int n;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        started = 1'b1;
        reset = 1'b0;

        send(8'h41);
        send(8'h42);
        send(8'h43);
        send(8'h44);
        send(8'h45);
        send(8'h0D);
        send(8'h0A);
        idle(1);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < COLS; i++) send(8'h61 + 8'(i % 26));
        send(8'h0A);
        send(8'h0A);
        send(8'h08);
        for (int i = 0; i < 4; i++) send(8'h77 + 8'(i));
        send(8'h08);
        send(8'h07);
        send(8'h9F);
        idle(2);

        send(8'h0A);
        rx_if.rx_valid = 1'b0;
        repeat (9) @(posedge clk);
        do_reset();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            send(rand_byte());
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
        end

        idle(1);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d writes outstanding, want 0", exp_q.size());
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/text_cursor_writer.md
# text_cursor_writer

Character-stream front end for the dual-port text buffer RAM. Accepts one byte per handshake from the UART receive path, interprets printable and control characters, and drives the RAM write port (we, w_row, w_col, din) while tracking a text cursor. Newlines and end-of-line wraps move the cursor to the next row and blank that row before more text is accepted.

## Interface
- ROWS, 4, number of text rows; must match the RAM.
- COLS, 32, number of text columns; must match the RAM.
- FILL_CHAR, 8'h20, byte written when blanking a row or erasing on backspace.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block can accept a byte; a byte is accepted on a rising edge where rx_valid & rx_ready.
- we  out  1  RAM write enable, registered.
- w_row  out  $clog2(ROWS)  RAM write row, registered.
- w_col  out  $clog2(COLS)  RAM write column, registered.
- din  out  8  RAM write data, registered.
- cur_row  out  $clog2(ROWS)  current cursor row.
- cur_col  out  $clog2(COLS)  current cursor column.

## Operation
- States: IDLE (accepting bytes) and CLEAR (blanking a row). rx_ready = (state == IDLE), combinational from the state register.
- Printable byte 0x20..0x7E accepted in IDLE:
  - Write it at (cur_row, cur_col).
  - If cur_col < COLS-1: cur_col+1, stay in IDLE.
  - If cur_col = COLS-1: cur_col=0, cur_row advances, and the block enters CLEAR.
- CR 0x0D: cur_col=0. No write.
- LF 0x0A: cur_row advances, cur_col=0, enter CLEAR. No write of the LF itself.
- Backspace 0x08:
  - If cur_col > 0: cur_col-1, and FILL_CHAR is written at the new position.
  - At cur_col = 0: no action.
- Any other byte is consumed and dropped: no write, no cursor change.
- Row advance: cur_row = (cur_row == ROWS-1) ? 0 : cur_row+1.
- CLEAR state:
  - An internal clr_col counter starts at 0.
  - One write per cycle of FILL_CHAR to (cur_row, clr_col) for clr_col = 0..COLS-1.
  - After issuing column COLS-1, return to IDLE.
- we is high only in cycles carrying a write. Otherwise we=0, and w_row, w_col and din hold their last values.
- Reset values: we=0, w_row=0, w_col=0, din=0, cur_row=0, cur_col=0, state=IDLE (rx_ready=1), clr_col=0.
- Reset asserted during CLEAR aborts the blanking immediately. Any remaining columns are not written.

## Timing
- A byte accepted at edge N has its write visible on we/w_row/w_col/din during cycle N+1 (latency 1). cur_row and cur_col update at edge N.
- In IDLE, printable bytes are accepted back-to-back, one per cycle, with one write per cycle.
- Entering CLEAR at edge N (via LF or a last-column wrap):
  - rx_ready is low during cycles N+1..N+COLS.
  - Fill writes for columns 0..COLS-1 are registered at edges N+1..N+COLS, so they are visible in cycles N+2..N+COLS+1.
  - rx_ready returns high in cycle N+COLS+1.
- On a wrap, the wrapping character's own write (cycle N+1) precedes the fill writes.
- The RAM's own reset clears memory independently. This block issues no writes while reset is high.

## Configuration
- TEXT_LINE_CLEAR_EN defined:
  - CLEAR state, clr_col counter and fill writes are compiled in, as described above.
- TEXT_LINE_CLEAR_EN undefined:
  - LF and last-column wrap only move the cursor; no fill writes are issued.
  - rx_ready is constant 1 outside reset, and the CLEAR logic is absent.

## Test plan
- After reset, send "AB" on consecutive cycles -> writes (0,0)=0x41 then (0,1)=0x42 in consecutive cycles; cursor ends at (0,2); rx_ready stays 1.
- Send 0x0D then 0x0A from (0,5) -> no write for CR; cursor goes to (1,0); 32 writes of 0x20 to row 1, columns 0..31; rx_ready low for exactly 32 cycles.
- Send 32 printable bytes starting at (3,0) -> last byte written at (3,31); cursor wraps to (0,0); row 0 is blanked.
- Backspace at (2,4) -> write 0x20 at (2,3); cursor at (2,3). Backspace at (2,0) -> no write, cursor unchanged.
- Send 0x07 and 0x9F -> both consumed with no write and no cursor change.
- Assert reset during the 10th fill write -> next cycle we=0, cursor (0,0), rx_ready=1. Repeat the LF test with TEXT_LINE_CLEAR_EN undefined -> no fill writes, rx_ready always 1.
